cpu_2432_dmem_resp: RTL and testbench

Data-memory responder for the 2432 CPU data port. It accepts byte-addressed read/write requests with per-lane write enables and returns read data one enabled cycle later. It contains a word-organised RAM and a small memory-mapped I/O register bank. I/O accesses add wait states by deasserting the CPU clock enable. It sits between the CPU core and the top-level clock-enable source.

---
 rtl/cpu_2432_dmem_resp.sv | 126 ++++++++++++
 tb/tb_cpu_2432_dmem_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_2432_dmem_resp.sv
// cpu_2432_dmem_resp: CPU data-port responder with word RAM, I/O registers and I/O wait states.
// Define CPU_2432_DMEM_BUS_ERR_EN to add the sticky o_bus_err flag for unmapped accesses.
module cpu_2432_dmem_resp #(
    parameter int RAM_AW  = 12,
    parameter int IO_WAIT = 2
) (
    input  logic        i_clk,
    input  logic        i_rstb,
    input  logic        i_clk_en,
    input  logic [23:0] i_daddr,
    input  logic [31:0] i_dout,
    input  logic        i_ram_rd,
    input  logic [3:0]  i_ram_wr,
    output logic [31:0] o_din,
    output logic        o_clk_en
`ifdef CPU_2432_DMEM_BUS_ERR_EN
    ,
    output logic        o_bus_err
`endif
);
    localparam int CW = IO_WAIT > 1 ? $clog2(IO_WAIT) : 1;
    localparam logic [31:0] ID = 32'h2432_0001;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              stall;
    logic [31:0]       mem [2**RAM_AW];
    logic [31:0]       cycles, scratch, reg3, io_data, rd_data, wmask;
    logic              io_sel, ram_sel, access, commit, wr_commit;
    logic [RAM_AW-1:0] idx;
    logic [1:0]        reg_sel;
    logic              unused_addr;

    assign io_sel      = i_daddr[23:20] == 4'hF;
    assign ram_sel     = (i_daddr >> (RAM_AW + 2)) == 24'd0;
    assign idx         = i_daddr[RAM_AW+1:2];
    assign reg_sel     = i_daddr[3:2];
    assign access      = i_ram_rd | (|i_ram_wr);
    assign o_clk_en    = i_clk_en & ~stall;
    assign commit      = o_clk_en & access;
    assign wr_commit   = o_clk_en & (|i_ram_wr);
    assign wmask       = {{8{i_ram_wr[3]}}, {8{i_ram_wr[2]}}, {8{i_ram_wr[1]}}, {8{i_ram_wr[0]}}};
    assign unused_addr = ^i_daddr[1:0];

    // The IDLE stall is combinational so the CPU freezes in the very cycle it presents an I/O access.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        if (IO_WAIT > 0) begin
            if (state == IDLE) begin
                if (io_sel && access) begin
                    stall     = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(IO_WAIT - 1);
                end
            end else if (cnt != '0) begin
                stall   = 1'b1;
                cnt_nxt = cnt - 1'b1;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (i_clk_en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef CPU_2432_DMEM_BUS_ERR_EN
    assign reg3 = {31'b0, o_bus_err};
`else
    assign reg3 = '0;
`endif

    always_comb begin
        io_data = reg_sel == 2'd0 ? cycles  :
                  reg_sel == 2'd1 ? scratch :
                  reg_sel == 2'd2 ? ID      : reg3;
        rd_data = io_sel ? io_data : ram_sel ? mem[idx] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            o_din   <= '0;
            cycles  <= '0;
            scratch <= '0;
        end else if (i_clk_en) begin
            if (commit && i_ram_rd)
                o_din <= rd_data;
            cycles <= (wr_commit && io_sel && reg_sel == 2'd0) ? '0 : cycles + 32'd1;
            if (wr_commit && io_sel && reg_sel == 2'd1)
                scratch <= (scratch & ~wmask) | (i_dout & wmask);
        end
    end

    // RAM has no reset; read-before-write falls out of the registered read above.
    always_ff @(posedge i_clk) begin
        if (i_rstb && wr_commit && ram_sel)
            for (int b = 0; b < 4; b++)
                if (i_ram_wr[b])
                    mem[idx][8*b +: 8] <= i_dout[8*b +: 8];
    end

`ifdef CPU_2432_DMEM_BUS_ERR_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstb)
            o_bus_err <= 1'b0;
        else if (i_clk_en) begin
            if (commit && !io_sel && !ram_sel)
                o_bus_err <= 1'b1;
            else if (wr_commit && io_sel && reg_sel == 2'd3)
                o_bus_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_2432_dmem_resp.sv
// tb_cpu_2432_dmem_resp: randomized bench against a transaction-level model of the data-memory responder.
module tb_cpu_2432_dmem_resp;
    localparam int RAM_AW  = 12;
    localparam int IO_WAIT = 2;

    logic        clk = 1'b0, rstb = 1'b0, clk_en = 1'b0, rd = 1'b0;
    logic [23:0] addr = '0;
    logic [31:0] dout = '0, din;
    logic [3:0]  wr = '0;
    logic        oce;
`ifdef CPU_2432_DMEM_BUS_ERR_EN
    logic        bus_err;
`endif

    always #5 clk = ~clk;

    cpu_2432_dmem_resp #(.RAM_AW(RAM_AW), .IO_WAIT(IO_WAIT)) dut (
        .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_daddr(addr), .i_dout(dout),
        .i_ram_rd(rd), .i_ram_wr(wr), .o_din(din), .o_clk_en(oce)
`ifdef CPU_2432_DMEM_BUS_ERR_EN
        , .o_bus_err(bus_err)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    logic [31:0] m_ram [int];
    logic [31:0] m_scratch = '0, m_cyc = '0, m_din = '0;
    bit          m_err = 1'b0, rand_en = 1'b0, c;
    logic [23:0] ram_addrs [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_io(logic [23:0] a);
        return a[23:20] == 4'hF;
    endfunction

    function automatic bit is_ram(logic [23:0] a);
        return int'(a) < (1 << (RAM_AW + 2));
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] l);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (l[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(logic [23:0] a);
        int i;
        i = int'(a) / 4;
        if (is_io(a)) begin
            case (int'(a[3:2]))
                0: return m_cyc;
                1: return m_scratch;
                2: return 32'h2432_0001;
`ifdef CPU_2432_DMEM_BUS_ERR_EN
                default: return {31'b0, m_err};
`else
                default: return 32'h0;
`endif
            endcase
        end
        if (is_ram(a)) return m_ram.exists(i) ? m_ram[i] : 32'hx;
        return 32'h0;
    endfunction

    // One clock: check the clock enable mid-cycle, then apply the edge to the model and check outputs.
    task automatic tick(input bit en, input bit exp_oce, output bit committed);
        logic [31:0] rv;
        bit clr;
        int i;
        clk_en = en;
        committed = 1'b0;
        @(negedge clk);
        chk("clk_en", {31'b0, oce}, {31'b0, exp_oce});
        @(posedge clk);
        if (!rstb) begin
            m_din = '0; m_cyc = '0; m_scratch = '0; m_err = 1'b0;
        end else if (en) begin
            clr = 1'b0;
            if (exp_oce && (rd || wr != 4'd0)) begin
                committed = 1'b1;
                rv = m_read(addr);
                i = int'(addr) / 4;
                if (rd) m_din = rv;
                if (!is_io(addr) && !is_ram(addr)) m_err = 1'b1;
                else if (wr != 4'd0) begin
                    if (is_io(addr)) begin
                        if (addr[3:2] == 2'd0) clr = 1'b1;
                        if (addr[3:2] == 2'd1) m_scratch = merge(m_scratch, dout, wr);
                        if (addr[3:2] == 2'd3) m_err = 1'b0;
                    end else
                        m_ram[i] = merge(m_ram.exists(i) ? m_ram[i] : 32'hx, dout, wr);
                end
            end
            m_cyc = clr ? 32'h0 : m_cyc + 32'd1;
        end
        #1;
        chk("din", din, m_din);
`ifdef CPU_2432_DMEM_BUS_ERR_EN
        chk("bus_err", {31'b0, bus_err}, {31'b0, m_err});
`endif
    endtask

    // A CPU access: held until the model expects IO_WAIT enabled stall cycles to have elapsed.
    task automatic xact(input logic [23:0] a, input bit r, input logic [3:0] w, input logic [31:0] d);
        int need, stalls;
        bit en, done;
        addr = a; rd = r; wr = w; dout = d;
        need = is_io(a) ? IO_WAIT : 0;
        stalls = 0;
        done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick(en, en && stalls >= need, done);
            if (!done && en) stalls++;
        end
        chk("xact_done", {31'b0, done}, 32'd1);
        rd = 1'b0; wr = '0;
    endtask

    task automatic idle(input int k);
        bit en;
        rd = 1'b0; wr = '0;
        for (int n = 0; n < k; n++) begin
            en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick(en, en, c);
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) ram_addrs[i] = 24'(16 + 16 * i);
        ram_addrs[7] = 24'h003FFC;
        tick(1'b1, 1'b1, c);
        tick(1'b0, 1'b0, c);
        tick(1'b1, 1'b1, c);
        rstb = 1'b1;
        for (int i = 0; i < 8; i++) xact(ram_addrs[i], 1'b0, 4'hF, $urandom);

        xact(24'h000010, 1'b0, 4'hF, 32'hDEAD_BEEF);
        xact(24'h000010, 1'b1, 4'h0, 32'h0);
        chk("ram_word", din, 32'hDEAD_BEEF);
        xact(24'h000020, 1'b0, 4'hF, 32'hAABB_CCDD);
        xact(24'h000020, 1'b0, 4'b0100, 32'h0011_0000);
        xact(24'h000020, 1'b1, 4'h0, 32'h0);
        chk("lane2", din, 32'hAA11_CCDD);
        xact(24'h000020, 1'b0, 4'b0011, 32'h0000_5566);
        xact(24'h000020, 1'b1, 4'h0, 32'h0);
        chk("lane01", din, 32'hAA11_5566);
        xact(24'h000020, 1'b1, 4'hF, 32'h1234_5678);
        chk("rd_before_wr", din, 32'hAA11_5566);
        xact(24'h000020, 1'b1, 4'h0, 32'h0);
        chk("wr_then_rd", din, 32'h1234_5678);

        xact(24'hF00008, 1'b1, 4'h0, 32'h0);
        chk("io_id", din, 32'h2432_0001);
        xact(24'hF00008, 1'b0, 4'hF, 32'h0);
        xact(24'hF00008, 1'b1, 4'h0, 32'h0);
        chk("id_ro", din, 32'h2432_0001);
        xact(24'hF00004, 1'b0, 4'hF, 32'h1122_3344);
        xact(24'hF00004, 1'b1, 4'h0, 32'h0);
        chk("scratch", din, 32'h1122_3344);

        xact(24'hF00000, 1'b0, 4'hF, 32'h0);
        idle(10);
        xact(24'hF00000, 1'b1, 4'h0, 32'h0);
        chk("cycles", din, 32'(10 + IO_WAIT));
        force dut.cycles = 32'hFFFF_FFFF;
        #1 release dut.cycles;
        m_cyc = 32'hFFFF_FFFF;
        xact(24'hF00000, 1'b1, 4'h0, 32'h0);
        chk("cycles_wrap", din, 32'(IO_WAIT - 1));

        addr = 24'hF00004; rd = 1'b0; wr = 4'hF; dout = 32'hCAFE_F00D;
        tick(1'b1, 1'b0, c);
        rstb = 1'b0;
        tick(1'b1, 1'b0, c);
        rstb = 1'b1; wr = '0;
        tick(1'b1, 1'b1, c);
        tick(1'b0, 1'b0, c);
        chk("rst_din", din, 32'h0);
        xact(24'hF00004, 1'b1, 4'h0, 32'h0);
        chk("rst_scratch", din, 32'h0);

`ifdef CPU_2432_DMEM_BUS_ERR_EN
        xact(24'h100000, 1'b1, 4'h0, 32'h0);
        chk("unmapped_rd", din, 32'h0);
        chk("err_set", {31'b0, bus_err}, 32'd1);
        xact(24'hF0000C, 1'b1, 4'h0, 32'h0);
        chk("reg3_rd", din, 32'd1);
        xact(24'hF0000C, 1'b0, 4'hF, 32'h0);
        chk("err_clr", {31'b0, bus_err}, 32'd0);
`endif

        rand_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int kind;
            bit r;
            logic [3:0] w;
            logic [23:0] a;
            kind = $urandom_range(0, 9);
            r = 1'($urandom_range(0, 1));
            w = 4'($urandom_range(0, 15));
            if (!r && w == 4'd0) r = 1'b1;
            if (kind <= 4) a = ram_addrs[$urandom_range(0, 7)];
            else if (kind <= 7) a = 24'hF00000 | 24'(4 * $urandom_range(0, 3));
            else a = 24'h100000 + 24'(4 * $urandom_range(0, 1023));
            if (kind == 9) idle($urandom_range(1, 3));
            else xact(a, r, w, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
